// File: rtl/sargantana_icache_ifill_if.sv
// Refill engine bundle: icache request/response plus the L2 read port, one interface per engine instance.
// The engine sits on the slave modport; the icache/L2 environment drives the master modport.
interface sargantana_icache_ifill_if #(
  parameter int PADDR_SIZE = 27,
  parameter int N_WAY      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int N_BEATS    = 4
);
  localparam int WAY_W  = $clog2(N_WAY);
  localparam int LINE_W = BEAT_WIDTH * N_BEATS;

  logic                  req_valid_i;
  logic [WAY_W-1:0]      req_way_i;
  logic [PADDR_SIZE-1:0] req_paddr_i;
  logic [1:0]            req_word_i;
  logic                  kill_i;
  logic                  resp_ack_o;
  logic                  resp_valid_o;
  logic [LINE_W-1:0]     resp_data_o;
  logic [1:0]            resp_beat_o;
  logic [WAY_W-1:0]      resp_way_o;
  logic                  resp_xcpt_o;
  logic                  busy_o;
  logic                  l2_req_valid_o;
  logic                  l2_req_ready_i;
  logic [PADDR_SIZE-1:0] l2_req_addr_o;
  logic [1:0]            l2_req_word_o;
  logic                  l2_resp_valid_i;
  logic [BEAT_WIDTH-1:0] l2_resp_data_i;
  logic                  l2_resp_err_i;

  modport slave (
    input  req_valid_i, req_way_i, req_paddr_i, req_word_i, kill_i,
    input  l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i, l2_resp_err_i,
    output resp_ack_o, resp_valid_o, resp_data_o, resp_beat_o, resp_way_o, resp_xcpt_o,
    output busy_o, l2_req_valid_o, l2_req_addr_o, l2_req_word_o
  );

  modport master (
    output req_valid_i, req_way_i, req_paddr_i, req_word_i, kill_i,
    output l2_req_ready_i, l2_resp_valid_i, l2_resp_data_i, l2_resp_err_i,
    input  resp_ack_o, resp_valid_o, resp_data_o, resp_beat_o, resp_way_o, resp_xcpt_o,
    input  busy_o, l2_req_valid_o, l2_req_addr_o, l2_req_word_o
  );
endinterface

// File: rtl/sargantana_icache_ifill.sv
// Icache line refill: one outstanding L2 read, 4 beats assembled into a 256-bit line; ICACHE_IFILL_CWF_EN enables critical-word-first.
// Latency: ack at T+1, line at T+6 with a zero-wait L2; L2 request held until ready, new requests taken only when idle.
module sargantana_icache_ifill #(
  parameter int PADDR_SIZE = 27,
  parameter int N_WAY      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int N_BEATS    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  sargantana_icache_ifill_if.slave bus
);
  localparam int WAY_W  = $clog2(N_WAY);
  localparam int LINE_W = BEAT_WIDTH * N_BEATS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] BEATS = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]            state_q;
  logic                  ack_q;
  logic [WAY_W-1:0]      way_q;
  logic [PADDR_SIZE-1:0] paddr_q;
  logic [1:0]            start_q;
  logic [1:0]            cnt_q;
  logic                  killed_q;
  logic                  err_q;
  logic [LINE_W-1:0]     line_q;
  logic [LINE_W-1:0]     line_next;
  logic [LINE_W-1:0]     resp_data_q;
  logic [WAY_W-1:0]      resp_way_q;
  logic [1:0]            resp_beat_q;
  logic                  xcpt_q;
  logic [1:0]            slot;
  logic [1:0]            req_start;

`ifdef ICACHE_IFILL_CWF_EN
  assign req_start = bus.req_word_i;
`else
  logic [1:0] unused_word;
  assign unused_word = bus.req_word_i;
  assign req_start   = 2'd0;
`endif

  // The 2-bit sum wraps, so beats land in start, start+1, ... mod 4.
  assign slot = start_q + cnt_q;

  always_comb begin
    line_next = line_q;
    line_next[int'(slot)*BEAT_WIDTH +: BEAT_WIDTH] = bus.l2_resp_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      way_q       <= '0;
      paddr_q     <= '0;
      start_q     <= '0;
      cnt_q       <= '0;
      killed_q    <= 1'b0;
      err_q       <= 1'b0;
      line_q      <= '0;
      resp_data_q <= '0;
      resp_way_q  <= '0;
      resp_beat_q <= '0;
      xcpt_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            way_q    <= bus.req_way_i;
            paddr_q  <= bus.req_paddr_i;
            start_q  <= req_start;
            cnt_q    <= '0;
            killed_q <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus.kill_i) killed_q <= 1'b1;
          if (bus.l2_req_ready_i) state_q <= BEATS;
        end
        BEATS: begin
          if (bus.kill_i) killed_q <= 1'b1;
          if (bus.l2_resp_valid_i) begin
            line_q <= line_next;
            cnt_q  <= cnt_q + 2'd1;
            err_q  <= err_q | bus.l2_resp_err_i;
            // A killed refill still drains all beats but never presents a line.
            if (cnt_q == 2'd3) begin
              if (killed_q || bus.kill_i) begin
                state_q <= IDLE;
              end else begin
                state_q     <= RESP;
                resp_data_q <= line_next;
                resp_way_q  <= way_q;
                resp_beat_q <= slot;
                xcpt_q      <= err_q | bus.l2_resp_err_i;
              end
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_ack_o     = ack_q;
  assign bus.resp_valid_o   = (state_q == RESP);
  assign bus.resp_data_o    = resp_data_q;
  assign bus.resp_beat_o    = resp_beat_q;
  assign bus.resp_way_o     = resp_way_q;
  assign bus.resp_xcpt_o    = xcpt_q;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.l2_req_valid_o = (state_q == REQ);
  assign bus.l2_req_addr_o  = paddr_q;
  assign bus.l2_req_word_o  = start_q;
endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Self-checking bench for sargantana_icache_ifill: scripted and random refills against a line-assembly model.
// Build with ICACHE_IFILL_CWF_EN defined to exercise critical-word-first ordering.
module tb_sargantana_icache_ifill;
  logic clk;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  logic [63:0]  s_data [4];
  int           s_gap  [4];
  logic [3:0]   s_err;

  int           r_n_ack, r_ack_at, r_ack2_at, r_n_resp, r_resp_at, r_last_at;
  logic [255:0] r_data, r_data_end, last_line;
  logic [1:0]   r_way, r_beat;
  logic         r_xcpt, r_busy_after, r_busy_end;
  bit           r_req_ok;

  sargantana_icache_ifill_if bus ();

  sargantana_icache_ifill dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i     = 1'b0;
    bus.kill_i          = 1'b0;
    bus.l2_req_ready_i  = 1'b0;
    bus.l2_resp_valid_i = 1'b0;
    bus.l2_resp_err_i   = 1'b0;
    bus.l2_resp_data_i  = '0;
  endtask

  // First line slot the L2 fills.
  function automatic logic [1:0] model_start(input logic [1:0] wd);
`ifdef ICACHE_IFILL_CWF_EN
    return wd;
`else
    return wd & 2'b00;
`endif
  endfunction

  // Beat i lands in slot (start + i) mod 4.
  function automatic logic [255:0] model_line(input logic [1:0] st);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 4; i++) l[((int'(st) + i) % 4) * 64 +: 64] = s_data[i];
    return l;
  endfunction

  // Drives one request at cycle 0 and plays the L2 side; kmode 1 = kill in REQ, 2 = kill on 4th beat, 3 = kill on 2nd beat.
  task automatic run_refill(input logic [26:0] pa, input logic [1:0] wy, input logic [1:0] wd,
                            input int delay, input int kmode, input bit hold);
    int phase, vcnt, gapcnt, bi;
    logic [1:0] exp_word;
    exp_word = model_start(wd);
    r_n_ack = 0; r_ack_at = -1; r_ack2_at = -1; r_n_resp = 0; r_resp_at = -1; r_last_at = -1;
    r_busy_after = 1'b0; r_req_ok = 1'b1;
    phase = 0; vcnt = 0; gapcnt = 0; bi = 0;
    idle_inputs();
    bus.req_valid_i = 1'b1; bus.req_paddr_i = pa; bus.req_way_i = wy; bus.req_word_i = wd;
    cyc();
    for (int c = 1; c < 150; c++) begin
      if (bus.resp_ack_o === 1'b1) begin
        r_n_ack++;
        if (r_ack_at < 0) r_ack_at = c; else r_ack2_at = c;
      end
      if (bus.resp_valid_o === 1'b1) begin
        r_n_resp++; r_resp_at = c;
        r_data = bus.resp_data_o; r_way = bus.resp_way_o; r_beat = bus.resp_beat_o; r_xcpt = bus.resp_xcpt_o;
      end
      if (phase == 2 && c == r_last_at + 1) r_busy_after = bus.busy_o;
      bus.req_valid_i     = hold && (phase < 2 || c <= r_last_at + 2);
      bus.kill_i          = (kmode == 1 && c == 1);
      bus.l2_req_ready_i  = 1'b0;
      bus.l2_resp_valid_i = 1'b0;
      bus.l2_resp_err_i   = 1'b0;
      bus.l2_resp_data_i  = {$urandom, $urandom};
      if (phase == 0) begin
        if (bus.l2_req_valid_o === 1'b1) begin
          if (bus.l2_req_addr_o !== pa || bus.l2_req_word_o !== exp_word) r_req_ok = 1'b0;
          if (vcnt >= delay) begin
            bus.l2_req_ready_i = 1'b1; phase = 1;
          end else vcnt++;
        end else if (vcnt > 0) r_req_ok = 1'b0;
      end else if (phase == 1) begin
        if (bus.l2_req_valid_o !== 1'b0 && !hold) r_req_ok = 1'b0;
        if (gapcnt < s_gap[bi]) gapcnt++;
        else begin
          bus.l2_resp_valid_i = 1'b1;
          bus.l2_resp_data_i  = s_data[bi];
          bus.l2_resp_err_i   = s_err[bi];
          if (kmode == 3 && bi == 1) bus.kill_i = 1'b1;
          if (bi == 3) begin
            r_last_at = c; phase = 2;
            if (kmode == 2) bus.kill_i = 1'b1;
          end
          bi++; gapcnt = 0;
        end
      end else if (c >= r_last_at + 5) break;
      cyc();
    end
    r_req_ok   = r_req_ok && (phase == 2);
    r_busy_end = bus.busy_o;
    r_data_end = bus.resp_data_o;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc(); cyc();
    n_asserts++;
    if ({bus.resp_ack_o, bus.resp_valid_o, bus.resp_xcpt_o, bus.busy_o, bus.l2_req_valid_o,
         bus.resp_beat_o, bus.resp_way_o, bus.l2_req_word_o} !== 11'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 0", {bus.resp_ack_o, bus.resp_valid_o,
        bus.resp_xcpt_o, bus.busy_o, bus.l2_req_valid_o, bus.resp_beat_o, bus.resp_way_o, bus.l2_req_word_o});
    end
    n_asserts++;
    if (bus.resp_data_o !== '0 || bus.l2_req_addr_o !== '0) begin
      n_fail++; $display("FAIL reset_data: data %h addr %h, required 0", bus.resp_data_o, bus.l2_req_addr_o);
    end
    rst = 1'b0;
    cyc();
    n_asserts++;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b, required 0", bus.busy_o); end
    last_line = '0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin s_data[i] = 64'hA0 + 64'(i); s_gap[i] = 0; end
    s_err = 4'b0;
    run_refill(27'h1234567, 2'd2, 2'd0, 0, 0, 1'b0);
    n_asserts++;
    if (r_ack_at !== 1 || r_n_ack !== 1) begin n_fail++; $display("FAIL basic_ack: at %0d count %0d, required at 1 count 1", r_ack_at, r_n_ack); end
    n_asserts++;
    if (r_resp_at !== 6 || r_n_resp !== 1) begin n_fail++; $display("FAIL basic_resp_time: at %0d count %0d, required at 6 count 1", r_resp_at, r_n_resp); end
    n_asserts++;
    if (r_data !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin n_fail++; $display("FAIL basic_data: got %h", r_data); end
    n_asserts++;
    if ({r_way, r_xcpt, r_beat} !== {2'd2, 1'b0, 2'd3}) begin n_fail++; $display("FAIL basic_fields: way %0d xcpt %b beat %0d, required 2 0 3", r_way, r_xcpt, r_beat); end
    n_asserts++;
    if (!r_req_ok || r_busy_after !== 1'b1 || r_busy_end !== 1'b0) begin
      n_fail++; $display("FAIL basic_l2_busy: req_ok %0d busy_after %b busy_end %b, required 1 1 0", r_req_ok, r_busy_after, r_busy_end);
    end
    last_line = r_data;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin s_data[i] = {$urandom, $urandom}; s_gap[i] = (i == 1) ? 3 : 0; end
    s_err = 4'b0;
    run_refill(27'h0ABCDEF, 2'd1, 2'd0, 5, 0, 1'b0);
    n_asserts++;
    if (!r_req_ok) begin n_fail++; $display("FAIL bp_l2_req_stable: req_ok %0d, required 1", r_req_ok); end
    n_asserts++;
    if (r_n_resp !== 1 || r_resp_at !== 14) begin n_fail++; $display("FAIL bp_resp: count %0d at %0d, required 1 at 14", r_n_resp, r_resp_at); end
    n_asserts++;
    if (r_data !== model_line(2'd0)) begin n_fail++; $display("FAIL bp_data: got %h required %h", r_data, model_line(2'd0)); end
    last_line = r_data;
  endtask

  task automatic test_error();
    for (int i = 0; i < 4; i++) begin s_data[i] = {$urandom, $urandom}; s_gap[i] = 0; end
    s_err = 4'b0010;
    run_refill(27'h0000040, 2'd0, 2'd0, 0, 0, 1'b0);
    n_asserts++;
    if (r_n_resp !== 1 || r_resp_at !== 6 || r_xcpt !== 1'b1) begin
      n_fail++; $display("FAIL error_xcpt: count %0d at %0d xcpt %b, required 1 at 6 xcpt 1", r_n_resp, r_resp_at, r_xcpt);
    end
    last_line = r_data;
    s_err = 4'b0;
  endtask

  task automatic test_kill();
    logic [255:0] exp;
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 4; i++) begin s_data[i] = {$urandom, $urandom}; s_gap[i] = 0; end
      run_refill(27'h5555555, 2'd3, 2'd0, 1, m, 1'b0);
      n_asserts++;
      if (r_n_resp !== 0 || r_busy_after !== 1'b0 || !r_req_ok) begin
        n_fail++; $display("FAIL kill_mode%0d: resp %0d busy_after %b req_ok %0d, required 0 0 1", m, r_n_resp, r_busy_after, r_req_ok);
      end
      n_asserts++;
      if (r_data_end !== last_line) begin n_fail++; $display("FAIL kill_hold_data%0d: got %h required %h", m, r_data_end, last_line); end
    end
    for (int i = 0; i < 4; i++) begin s_data[i] = {$urandom, $urandom}; s_gap[i] = 0; end
    run_refill(27'h2468ACE, 2'd1, 2'd0, 0, 0, 1'b0);
    exp = model_line(2'd0);
    n_asserts++;
    if (r_ack_at !== 1 || r_n_resp !== 1 || r_data !== exp || r_way !== 2'd1) begin
      n_fail++; $display("FAIL kill_next_req: ack %0d resp %0d way %0d data %h, required 1 1 1 %h", r_ack_at, r_n_resp, r_way, r_data, exp);
    end
    last_line = r_data;
  endtask

  task automatic test_cwf();
    logic [255:0] exp;
    logic [1:0]   exp_beat;
    for (int i = 0; i < 4; i++) begin s_data[i] = 64'hB0 + 64'(i); s_gap[i] = 0; end
`ifdef ICACHE_IFILL_CWF_EN
    exp = {64'hB1, 64'hB0, 64'hB3, 64'hB2}; exp_beat = 2'd1;
`else
    exp = {64'hB3, 64'hB2, 64'hB1, 64'hB0}; exp_beat = 2'd3;
`endif
    run_refill(27'h7654321, 2'd3, 2'd2, 0, 0, 1'b0);
    n_asserts++;
    if (r_data !== exp) begin n_fail++; $display("FAIL cwf_data: got %h required %h", r_data, exp); end
    n_asserts++;
    if ({r_way, r_xcpt, r_beat} !== {2'd3, 1'b0, exp_beat} || !r_req_ok) begin
      n_fail++; $display("FAIL cwf_fields: way %0d xcpt %b beat %0d req_ok %0d, required 3 0 %0d 1", r_way, r_xcpt, r_beat, r_req_ok, exp_beat);
    end
    last_line = r_data;
  endtask

  // Leaves the DUT holding a second accepted request in REQ.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin s_data[i] = {$urandom, $urandom}; s_gap[i] = 0; end
    run_refill(27'h1111111, 2'd3, 2'd0, 0, 0, 1'b1);
    n_asserts++;
    if (r_n_ack !== 2 || r_ack2_at !== r_last_at + 3 || r_n_resp !== 1) begin
      n_fail++; $display("FAIL b2b_accept: acks %0d second at %0d resp %0d, required 2 at %0d resp 1", r_n_ack, r_ack2_at, r_n_resp, r_last_at + 3);
    end
    n_asserts++;
    if (r_busy_end !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b required 1", r_busy_end); end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    bus.req_valid_i = 1'b1;
    bus.l2_req_ready_i = 1'b1;
    cyc();
    bus.l2_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus.resp_ack_o === 1'b1) acks++;
      bus.l2_resp_valid_i = (k < 2);
      bus.l2_resp_data_i  = {$urandom, $urandom};
      cyc();
    end
    if (bus.resp_ack_o === 1'b1) acks++;
    n_asserts++;
    if (acks !== 0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_no_ack: acks %0d busy %b, required 0 1", acks, bus.busy_o); end
    idle_inputs();
    rst = 1'b1;
    cyc();
    n_asserts++;
    if ({bus.resp_ack_o, bus.resp_valid_o, bus.resp_xcpt_o, bus.busy_o, bus.l2_req_valid_o,
         bus.resp_beat_o, bus.resp_way_o, bus.l2_req_word_o} !== 11'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b, required 0", {bus.resp_ack_o, bus.resp_valid_o,
        bus.resp_xcpt_o, bus.busy_o, bus.l2_req_valid_o, bus.resp_beat_o, bus.resp_way_o, bus.l2_req_word_o});
    end
    n_asserts++;
    if (bus.resp_data_o !== '0 || bus.l2_req_addr_o !== '0) begin
      n_fail++; $display("FAIL midreset_data: data %h addr %h, required 0", bus.resp_data_o, bus.l2_req_addr_o);
    end
    rst = 1'b0;
    cyc();
    last_line = '0;
  endtask

  task automatic test_random();
    logic [26:0]  pa;
    logic [1:0]   wy, wd, st;
    int           km;
    logic [255:0] exp;
    for (int it = 0; it < 12; it++) begin
      pa = 27'($urandom); wy = 2'($urandom); wd = 2'($urandom);
      km = $urandom_range(0, 6);
      if (km > 3) km = 0;
      for (int i = 0; i < 4; i++) begin s_data[i] = {$urandom, $urandom}; s_gap[i] = $urandom_range(0, 2); end
      s_err = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      st  = model_start(wd);
      exp = model_line(st);
      run_refill(pa, wy, wd, $urandom_range(0, 3), km, 1'b0);
      n_asserts++;
      if (!r_req_ok || r_ack_at !== 1 || r_busy_end !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_handshake: req_ok %0d ack %0d busy_end %b", it, r_req_ok, r_ack_at, r_busy_end);
      end
      if (km == 0) begin
        n_asserts++;
        if (r_n_resp !== 1 || r_resp_at !== r_last_at + 1 || r_data !== exp) begin
          n_fail++; $display("FAIL rand%0d_line: count %0d at %0d data %h, required 1 at %0d %h", it, r_n_resp, r_resp_at, r_data, r_last_at + 1, exp);
        end
        n_asserts++;
        if ({r_way, r_xcpt, r_beat} !== {wy, |s_err, 2'(st + 2'd3)}) begin
          n_fail++; $display("FAIL rand%0d_fields: way %0d xcpt %b beat %0d, required %0d %b %0d", it, r_way, r_xcpt, r_beat, wy, |s_err, 2'(st + 2'd3));
        end
        last_line = exp;
      end else begin
        n_asserts++;
        if (r_n_resp !== 0 || r_busy_after !== 1'b0 || r_data_end !== last_line) begin
          n_fail++; $display("FAIL rand%0d_kill%0d: resp %0d busy_after %b data %h, required 0 0 %h", it, km, r_n_resp, r_busy_after, r_data_end, last_line);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_way_i = '0; bus.req_paddr_i = '0; bus.req_word_i = '0;
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_kill();
    test_cwf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
